// File: rtl/if_id_reg_pkg.sv
// if_id_reg_pkg: shared clear polarity, NOP encoding and pipeline-register state codes.
// Contents:
//   CLEAR_ENABLE / CLEAR_DISABLE  levels of the jump-control flush request
//   NOP_ENC                       instruction word injected into decode on a flush or bubble
//   state_e                       RUN / HOLD / DRAIN state codes
`ifndef IF_ID_REG_PKG_SV
`define IF_ID_REG_PKG_SV
package if_id_reg_pkg;
    localparam logic        CLEAR_ENABLE  = 1'b1;
    localparam logic        CLEAR_DISABLE = 1'b0;
    localparam logic [31:0] NOP_ENC       = 32'h0000_7000;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_e;
endpackage
`endif

// File: rtl/if_id_reg.sv
// if_id_reg: fetch/decode pipeline register with stall hold, flush and wrong-path drain.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-low reset
//   clear                 flush request from jump control (active at CLEAR_ENABLE)
//   stall                 hold request from hazard unit, active-high
//   in_pc/in_inst/in_valid     fetch-stage payload
//   out_pc/out_inst/out_valid  registered decode-stage payload
//   draining              high while wrong-path fetches are being dropped
//   squash_cnt            count of discarded instructions (only with IF_ID_SQUASH_CNT_EN)
// Build option: define IF_ID_SQUASH_CNT_EN to add the saturating squash counter.
module if_id_reg
    import if_id_reg_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int INST_W  = 16,
    parameter int DRAIN_N = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              stall,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic              in_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_valid,
    output logic              draining
`ifdef IF_ID_SQUASH_CNT_EN
   ,output logic [15:0]       squash_cnt
`endif
);
    localparam logic [INST_W-1:0] NOP     = INST_W'(NOP_ENC);
    localparam logic [2:0]        DRAIN_C = 3'(DRAIN_N);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;
    logic [2:0]        cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (clear == CLEAR_ENABLE) begin
            // flush kills the decode entry but keeps its pc for debug visibility
            valid_d = 1'b0;
            inst_d  = NOP;
            cnt_d   = DRAIN_C;
            state_d = DRAIN;
        end else if (stall) begin
            if (state_q != DRAIN) state_d = HOLD;
        end else if (state_q == DRAIN) begin
            // only real, unstalled fetches count as dropped wrong-path work
            if (in_valid) begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = RUN;
            end
        end else begin
            state_d = RUN;
            pc_d    = in_pc;
            inst_d  = in_valid ? in_inst : NOP;
            valid_d = in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            pc_q    <= '0;
            inst_q  <= NOP;
            valid_q <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_pc    = pc_q;
    assign out_inst  = inst_q;
    assign out_valid = valid_q;
    assign draining  = (state_q == DRAIN);

`ifdef IF_ID_SQUASH_CNT_EN
    logic [15:0] sq_q, sq_d;
    logic        kill;

    // a flush kills at most the live decode entry; a drain cycle drops one fetch
    assign kill = (clear == CLEAR_ENABLE) ? valid_q
                                          : (!stall && state_q == DRAIN && in_valid);
    assign sq_d = (kill && sq_q != 16'hFFFF) ? sq_q + 16'd1 : sq_q;

    always_ff @(posedge clk) begin
        if (!rst) sq_q <= 16'd0;
        else      sq_q <= sq_d;
    end

    assign squash_cnt = sq_q;
`endif
endmodule

// File: tb/tb_if_id_reg.sv
// tb_if_id_reg: directed-vector self-checking bench for if_id_reg (DRAIN_N=2).
module tb_if_id_reg;
    import if_id_reg_pkg::*;

    localparam logic [15:0] NOP = NOP_ENC[15:0];

    logic        clk = 1'b0;
    logic        rst, clear, stall, in_valid;
    logic [15:0] in_pc, in_inst;
    logic [15:0] out_pc, out_inst;
    logic        out_valid, draining;
`ifdef IF_ID_SQUASH_CNT_EN
    logic [15:0] squash_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    if_id_reg #(.PC_W(16), .INST_W(16), .DRAIN_N(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .stall     (stall),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_valid  (in_valid),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_valid (out_valid),
        .draining  (draining)
`ifdef IF_ID_SQUASH_CNT_EN
       ,.squash_cnt(squash_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic s, input logic v,
                         input logic [15:0] pc, input logic [15:0] inst);
        clear    = c ? CLEAR_ENABLE : CLEAR_DISABLE;
        stall    = s;
        in_valid = v;
        in_pc    = pc;
        in_inst  = inst;
    endtask

    initial begin
        rst = 1'b0;
        drive(1, 1, 1, 16'hDEAD, 16'hBEEF);
        step();
        check("rst_valid", out_valid, 0);
        check("rst_pc", out_pc, 0);
        check("rst_inst", out_inst, NOP);
        check("rst_drain", draining, 0);

        rst = 1'b1;
        drive(0, 0, 1, 16'h0010, 16'h1234);
        step();
        check("load_pc", out_pc, 16'h0010);
        check("load_inst", out_inst, 16'h1234);
        check("load_valid", out_valid, 1);

        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 16'h0020 + 16'(i), 16'hA000 + 16'(i));
            step();
            check("stall_pc", out_pc, 16'h0010);
            check("stall_inst", out_inst, 16'h1234);
            check("stall_valid", out_valid, 1);
        end
        drive(0, 0, 1, 16'h0020, 16'hA000);
        step();
        check("unstall_pc", out_pc, 16'h0020);
        check("unstall_inst", out_inst, 16'hA000);

        drive(0, 0, 0, 16'h0030, 16'h5678);
        step();
        check("bubble_valid", out_valid, 0);
        check("bubble_inst", out_inst, NOP);

        drive(0, 0, 1, 16'h0040, 16'h1111);
        step();
        check("reload_valid", out_valid, 1);

        drive(1, 1, 1, 16'h0050, 16'h2222);
        step();
        check("clr_valid", out_valid, 0);
        check("clr_inst", out_inst, NOP);
        check("clr_pc", out_pc, 16'h0040);
        check("clr_drain", draining, 1);

        drive(0, 0, 0, 16'h0058, 16'h2A2A);
        step();
        check("drain_idle", draining, 1);
        drive(0, 0, 1, 16'h0060, 16'h3333);
        step();
        check("drop1_drain", draining, 1);
        check("drop1_valid", out_valid, 0);
        drive(0, 1, 1, 16'h0070, 16'h3444);
        step();
        check("drain_stall", draining, 1);
        drive(0, 0, 1, 16'h0070, 16'h3444);
        step();
        check("drop2_drain", draining, 0);
        check("drop2_valid", out_valid, 0);
`ifdef IF_ID_SQUASH_CNT_EN
        check("squash_cnt", squash_cnt, 3);
`endif
        drive(0, 0, 1, 16'h0080, 16'h4444);
        step();
        check("post_pc", out_pc, 16'h0080);
        check("post_inst", out_inst, 16'h4444);
        check("post_valid", out_valid, 1);

        drive(1, 0, 0, 16'h0000, 16'h0000);
        step();
        drive(0, 0, 1, 16'h0090, 16'h5555);
        step();
        check("re_drop1", draining, 1);
        drive(1, 0, 1, 16'h0091, 16'h5556);
        step();
        check("re_clear", draining, 1);
        drive(0, 0, 1, 16'h0092, 16'h5557);
        step();
        check("re_drop2", draining, 1);
        check("re_drop2_valid", out_valid, 0);
        drive(0, 0, 1, 16'h0093, 16'h5558);
        step();
        check("re_drop3", draining, 0);
        drive(0, 0, 1, 16'h0094, 16'h5559);
        step();
        check("re_load_pc", out_pc, 16'h0094);
        check("re_load_valid", out_valid, 1);

        drive(1, 0, 1, 16'h00A0, 16'h6666);
        step();
        check("pre_rst_drain", draining, 1);
        rst = 1'b0;
        drive(1, 1, 1, 16'h00A1, 16'h6667);
        step();
        check("mid_rst_drain", draining, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_pc", out_pc, 0);
        check("mid_rst_inst", out_inst, NOP);
`ifdef IF_ID_SQUASH_CNT_EN
        check("squash_rst", squash_cnt, 0);
`endif
        rst = 1'b1;
        drive(0, 0, 1, 16'h00B0, 16'h7777);
        step();
        check("after_rst_pc", out_pc, 16'h00B0);
        check("after_rst_valid", out_valid, 1);
        check("after_rst_drain", draining, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 SHALL have parameter PC_W, 16, program-counter width.
REQ-002 SHALL have parameter INST_W, 16, instruction width.
REQ-003 SHALL have parameter DRAIN_N, 1, wrong-path fetches dropped after a clear (1..7).
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port clear  in  1  flush request from jump control, active at CLEAR_ENABLE.
REQ-007 SHALL have port stall  in  1  hold request from hazard unit, active-high.
REQ-008 SHALL have ports in_pc  in  PC_W, in_inst  in  INST_W, in_valid  in  1  fetch-stage payload.
REQ-009 SHALL have ports out_pc  out  PC_W, out_inst  out  INST_W, out_valid  out  1  decode-stage payload, all registered.
REQ-010 SHALL have port draining  out  1  high while in DRAIN state.

Function
REQ-011 SHALL implement states RUN, HOLD, DRAIN; all outputs update only on rising clk.
REQ-012 Priority per cycle SHALL be: rst > clear > stall > load.
REQ-013 RUN, no clear/stall: out_* <= in_*; latency one cycle.
REQ-014 RUN/HOLD with stall and no clear: out_* held unchanged; state HOLD; input not consumed.
REQ-015 HOLD with stall low and no clear: load as REQ-013; state RUN.
REQ-016 clear in any state, including with stall: out_valid <= 0, out_inst <= NOP, out_pc held; in_* of that cycle discarded; drain counter <= DRAIN_N; state DRAIN.
REQ-017 DRAIN: counter decrements only in cycles with in_valid=1 and stall=0; each such fetch discarded; out_valid stays 0.
REQ-018 DRAIN: when counter reaches 0 by decrement, state RUN next cycle; the next fetch loads normally.
REQ-019 clear while in DRAIN SHALL reload counter to DRAIN_N (restart).
REQ-020 in_valid=0 in RUN without stall: out_valid <= 0, out_inst <= NOP (bubble).
REQ-021 draining SHALL equal (state==DRAIN), registered.

Reset
REQ-022 rst=0 at a rising edge: state RUN, out_pc 0, out_inst NOP, out_valid 0, draining 0, counter 0, overriding clear and stall.
REQ-023 rst asserted mid-DRAIN SHALL abandon the drain; no pending drop survives reset.

Configuration
REQ-024 Macro IF_ID_SQUASH_CNT_EN defined: extra port squash_cnt  out  16  counts instructions discarded by clear or drain (out_valid-1 entries killed plus dropped fetches), saturating at 0xFFFF, reset to 0.
REQ-025 Macro undefined: port squash_cnt and its logic absent; all other behaviour identical.

Structure
REQ-026 CLEAR_ENABLE, CLEAR_DISABLE, NOP encoding and state codes SHALL reside in shared define.v, guarded against double inclusion.
REQ-027 No sub-module; drain counter and FSM inline.

Verification
REQ-028 Reset then in_pc=0x0010, in_inst=0x1234, in_valid=1 -> next cycle out_pc=0x0010, out_inst=0x1234, out_valid=1.
REQ-029 out_valid=1, stall=1 for 3 cycles with changing in_* -> outputs unchanged 3 cycles, then load first input after stall drops.
REQ-030 DRAIN_N=2, clear with stall=1 -> out_valid=0, NOP, draining=1; next two valid unstalled fetches dropped; third appears with out_valid=1.
REQ-031 DRAIN_N=2, clear, one drop, clear again -> counter reloads; two further drops required before RUN.
REQ-032 rst=0 in DRAIN with clear=1 -> RUN, all outputs reset values, draining=0 next cycle.
REQ-033 IF_ID_SQUASH_CNT_EN, DRAIN_N=1, clear with out_valid=1 then one dropped fetch -> squash_cnt=2; preset 0xFFFF stays 0xFFFF.
